bus_mem_responder: RTL
======================

// Module: bus_mem_responder
// PURPOSE
//  Memory-side responder on the shared 8-bit d_bus, opposite end of the ALU datapath.
//  Decodes the ALU instruction, sequences a 32x8 data store with programmable wait states.
//  Drives the operand onto d_bus for ADD/SUB/NAND/LD; captures d_bus into the store for ST.
//  Sits between the instruction sequencer and the ALU; sole memory-side d_bus driver.
// PARAMETERS
//  DATA_W       8   d_bus and store word width
//  ADDR_W       5   store address width = instruction[4:0]; depth = 2**ADDR_W
//  WAIT_CYCLES  1   memory wait states before drive/capture, legal 0..7
// PORTS
//  tclk       in     1       clock, all state updates on rising edge
//  reset      in     1       synchronous, active-high reset
//  start      in     1       1-cycle pulse: accept instruction (ignored while busy)
//  instruction in    8       [7:5] opcode, [4:0] store address
//  d_bus      inout  DATA_W  shared data bus; high-Z unless in DRIVE
//  busy       out    1       high from accept until the cycle after done
//  done       out    1       1-cycle pulse: access phase complete
//  rd_data    out    DATA_W  registered copy of last word read from store
//  dbg_we     in     1       debug/preload write strobe
//  dbg_addr   in     ADDR_W  debug write address
//  dbg_wdata  in     DATA_W  debug write data
//  dbg_err    out    1       1-cycle pulse: dbg_we dropped because busy
//  par_err    out    1       sticky parity error (PARITY_EN only; else tied 0)
// BEHAVIOUR
//  Opcodes: 000 ADD,001 SUB,010 NAND,100 LD = READ; 101 ST = WRITE; 011 SHIFT,11x = NOP.
//  Reset: state IDLE, busy=0, done=0, rd_data=0, dbg_err=0, par_err=0, d_bus=Z,
//   wait counter=0. Store contents NOT reset. Reset mid-op aborts; no store write.
//  FSM IDLE -> (start) latch instruction into ir, busy=1:
//   READ : WAIT x WAIT_CYCLES -> DRIVE (1 cycle) -> IDLE.
//   WRITE: WAIT x WAIT_CYCLES -> CAPTURE (1 cycle) -> IDLE.
//   NOP  : DONE (1 cycle) -> IDLE; no store access, d_bus stays Z.
//   WAIT_CYCLES=0 skips WAIT entirely.
//  DRIVE: d_bus = mem[ir[4:0]]; rd_data loaded same edge; done=1.
//  CAPTURE: mem[ir[4:0]] <= d_bus sampled at end of cycle; done=1.
//  Latency start->done: 1+WAIT_CYCLES cycles (done in cycle 1+WAIT_CYCLES, start=cycle 0).
//  busy deasserts on the edge ending the done cycle; new start accepted that next cycle.
//  start while busy: ignored, no effect on ir or state.
//  dbg_we in IDLE without start: mem[dbg_addr] <= dbg_wdata. dbg_we with start same
//   cycle: debug write performed first-in-time; a READ of the same address returns
//   the new data. dbg_we while busy: dropped, dbg_err pulses next cycle.
//  d_bus released (Z) every state except DRIVE; never driven in the cycle after reset.
//  Address 5'h1f is an ordinary store location (SHIFT direction is ALU-side only).
// CONFIGURATION
//  PARITY_EN defined: store holds DATA_W+1 bits, even parity written on CAPTURE and
//   debug writes; on DRIVE, mismatch sets par_err (sticky until reset); data still driven.
//  PARITY_EN undefined: store DATA_W bits, par_err constant 0.
// TESTING
//  Reset, then idle 3 cycles -> d_bus Z, busy/done/rd_data/par_err all 0.
//  dbg write 8'hA5 @5'h03; start LD(8'h83), WAIT_CYCLES=1 -> done in cycle 2, d_bus=8'hA5, rd_data=8'hA5.
//  start ST(8'hA7) with bench driving d_bus=8'h3C in CAPTURE; then ADD(8'h07) -> drives 8'h3C.
//  start SHIFT(8'h7F) -> done in cycle 1, d_bus Z throughout, store unchanged.
//  start LD then start again + dbg_we in busy -> second start ignored, dbg_err 1 pulse, one done.
//  Assert reset during WAIT of ST @5'h04 (preloaded 8'h11) -> IDLE, d_bus Z, LD 8'h84 returns 8'h11.

Source files
------------

// File: rtl/bus_mem_responder.sv
// Memory-side d_bus responder: decodes the ALU opcode and sequences a 32x8 store with wait states.
// Optional store parity is enabled by defining PARITY_EN at compile time.
module bus_mem_responder #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 5,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              tclk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        instruction,
  inout  wire  [DATA_W-1:0] d_bus,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_err,
  output logic              par_err
);

  // state   | meaning
  // IDLE    | waiting for start; debug writes allowed
  // WAIT    | memory wait states, down-counter runs to zero
  // DRIVE   | read word on d_bus, done pulse
  // CAPTURE | d_bus written into store at end of cycle, done pulse
  // DONE    | no-access opcode completes, done pulse
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_DRIVE   = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

`ifdef PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  localparam logic [2:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

  function automatic logic is_read_op(input logic [2:0] op);
    return (op == 3'b000) || (op == 3'b001) || (op == 3'b010) || (op == 3'b100);
  endfunction

  function automatic logic is_write_op(input logic [2:0] op);
    return (op == 3'b101);
  endfunction

  function automatic logic [MEM_W-1:0] encode(input logic [DATA_W-1:0] d);
`ifdef PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  state_t            state, state_nxt;
  logic [7:0]        ir;
  logic [2:0]        wait_cnt;
  logic              drive_en;
  logic              accept;
  logic              dbg_wr;
  logic              cap_wr;
  logic [ADDR_W-1:0] read_addr;
  logic [MEM_W-1:0]  read_word;
  logic [MEM_W-1:0]  mem [2**ADDR_W];

  always_ff @(posedge tclk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (is_read_op(instruction[7:5]))
            state_nxt = (WAIT_CYCLES == 0) ? S_DRIVE : S_WAIT;
          else if (is_write_op(instruction[7:5]))
            state_nxt = (WAIT_CYCLES == 0) ? S_CAPTURE : S_WAIT;
          else
            state_nxt = S_DONE;
        end
      end
      S_WAIT: begin
        if (wait_cnt == 3'd0)
          state_nxt = is_write_op(ir[7:5]) ? S_CAPTURE : S_DRIVE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != S_IDLE);
    done     = (state == S_DRIVE) || (state == S_CAPTURE) || (state == S_DONE);
    drive_en = (state == S_DRIVE);
  end

  assign accept = (state == S_IDLE) && start;
  assign dbg_wr = (state == S_IDLE) && dbg_we && !reset;
  assign cap_wr = (state == S_CAPTURE) && !reset;

  // A debug write in the accept cycle lands first, so bypass it into the read path.
  assign read_addr = (state == S_IDLE) ? instruction[ADDR_W-1:0] : ir[ADDR_W-1:0];
  assign read_word = (state == S_IDLE && dbg_we && dbg_addr == read_addr) ?
                     encode(dbg_wdata) : mem[read_addr];

  always_ff @(posedge tclk) begin
    if (reset) begin
      ir       <= '0;
      wait_cnt <= '0;
      rd_data  <= '0;
      dbg_err  <= 1'b0;
    end else begin
      if (accept) ir <= instruction;
      if (accept)
        wait_cnt <= WAIT_LOAD;
      else if (state == S_WAIT && wait_cnt != 3'd0)
        wait_cnt <= wait_cnt - 3'd1;
      if (state_nxt == S_DRIVE) rd_data <= read_word[DATA_W-1:0];
      dbg_err <= dbg_we && busy;
    end
  end

  // Store contents deliberately survive reset.
  always_ff @(posedge tclk) begin
    if (cap_wr)
      mem[ir[ADDR_W-1:0]] <= encode(d_bus);
    else if (dbg_wr)
      mem[dbg_addr] <= encode(dbg_wdata);
  end

  assign d_bus = drive_en ? rd_data : {DATA_W{1'bz}};

`ifdef PARITY_EN
  logic rd_par;

  always_ff @(posedge tclk) begin
    if (reset) begin
      rd_par  <= 1'b0;
      par_err <= 1'b0;
    end else begin
      if (state_nxt == S_DRIVE) rd_par <= read_word[DATA_W];
      if (state == S_DRIVE && (^{rd_par, rd_data})) par_err <= 1'b1;
    end
  end
`else
  assign par_err = 1'b0;
`endif

endmodule
